// File: rtl/column_readout_rr.sv
// rtl/column_readout_rr.sv - super-pixel column readout: hit sync, timestamp/count capture, round-robin drain into FWFT FIFO
module column_readout_fifo #(
   parameter int W     = 13,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         valid,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   assign valid = (count != '0);
   assign full  = (count == (PW+1)'(DEPTH));
   assign rdata = valid ? mem[rd_ptr] : '0;
endmodule

module column_readout_rr #(
   parameter int N_PIX      = 16,
   parameter int TS_W       = 9,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int LOST_W     = 8,
   localparam int AW        = $clog2(N_PIX)
) (
   input  logic                 clk_40MHz,
   input  logic                 rst,
   input  logic                 shutter,
   input  logic                 mode,
   input  logic [N_PIX-1:0]     hit,
   input  logic [TS_W-1:0]      TimeStamp,
   input  logic                 shake_hands_col,
   output logic [AW+TS_W-1:0]   col_data,
   output logic                 col_valid,
   output logic                 hit_or_column,
   output logic [LOST_W-1:0]    lost_cnt
);
   localparam int LOST_MAX = (1 << LOST_W) - 1;

   logic [N_PIX-1:0] s1, s2, s3, hit_edge;
   logic             shutter_q, shutter_q2, mode_q;
   logic             shutter_fall, shutter_rise, mode_chg;

   logic [N_PIX-1:0] flag, flag_n;
   logic [TS_W-1:0]  ts   [N_PIX];
   logic [TS_W-1:0]  ts_n [N_PIX];
   logic [CNT_W-1:0] cnt   [N_PIX];
   logic [CNT_W-1:0] cnt_n [N_PIX];

   logic [AW-1:0]    rr_ptr, rr_ptr_n, gnt_idx;
   logic             gnt_found, gnt_valid;
   logic [TS_W-1:0]  gnt_payload;
   logic [LOST_W-1:0] lost_n;
   logic             fifo_full, fifo_pop;

   assign hit_edge      = s2 & ~s3;
   assign shutter_fall  = shutter_q2 & ~shutter_q;
   assign shutter_rise  = shutter_q & ~shutter_q2;
   assign mode_chg      = (mode != mode_q);
   assign hit_or_column = |flag;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_PIX; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_PIX) idx = idx - N_PIX;
         if (!gnt_found && flag[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = AW'(idx);
         end
      end
   end

   assign gnt_valid   = gnt_found && !fifo_full;
   assign gnt_payload = mode_q ? TS_W'(cnt[gnt_idx]) : ts[gnt_idx];
   assign fifo_pop    = col_valid && shake_hands_col;

   always_comb begin
      rr_ptr_n = rr_ptr;
      if (gnt_valid) rr_ptr_n = (gnt_idx == AW'(N_PIX-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_comb begin
      int   n_lost;
      int   lost_sum;
      logic granted;
      logic new_hit;
      flag_n   = flag;
      ts_n     = ts;
      cnt_n    = cnt;
      n_lost   = 0;
      lost_sum = 0;
      granted  = 1'b0;
      new_hit  = 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
         granted = gnt_valid && (gnt_idx == AW'(i));
         new_hit = hit_edge[i] && shutter;
         if (!mode_q) begin
            // A grant frees the slot in the same cycle, so a coinciding hit re-arms it.
            if (new_hit && (!flag[i] || granted)) begin
               flag_n[i] = 1'b1;
               ts_n[i]   = TimeStamp;
            end else if (granted) begin
               flag_n[i] = 1'b0;
            end
            if (new_hit && flag[i] && !granted) n_lost = n_lost + 1;
         end else begin
            if (granted) flag_n[i] = 1'b0;
            if (shutter_fall && (cnt[i] != '0) && !granted) flag_n[i] = 1'b1;
            if (new_hit)
               cnt_n[i] = granted ? CNT_W'(1) :
                          (cnt[i] == {CNT_W{1'b1}}) ? cnt[i] : cnt[i] + 1'b1;
            else if (granted)
               cnt_n[i] = '0;
         end
         if (mode_chg) begin
            flag_n[i] = 1'b0;
            ts_n[i]   = '0;
            cnt_n[i]  = '0;
         end
      end
      lost_sum = int'(lost_cnt) + n_lost;
      if (lost_sum > LOST_MAX) lost_sum = LOST_MAX;
      lost_n = shutter_rise ? '0 : LOST_W'(lost_sum);
   end

   always_ff @(posedge clk_40MHz or posedge rst) begin
      if (rst) begin
         s1         <= '0;
         s2         <= '0;
         s3         <= '0;
         shutter_q  <= 1'b0;
         shutter_q2 <= 1'b0;
         mode_q     <= 1'b0;
         flag       <= '0;
         rr_ptr     <= '0;
         lost_cnt   <= '0;
         for (int i = 0; i < N_PIX; i++) begin
            ts[i]  <= '0;
            cnt[i] <= '0;
         end
      end else begin
         s1         <= hit;
         s2         <= s1;
         s3         <= s2;
         shutter_q  <= shutter;
         shutter_q2 <= shutter_q;
         mode_q     <= mode;
         flag       <= flag_n;
         rr_ptr     <= rr_ptr_n;
         lost_cnt   <= lost_n;
         ts         <= ts_n;
         cnt        <= cnt_n;
      end
   end

   column_readout_fifo #(
      .W     (AW + TS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_40MHz),
      .rst   (rst),
      .push  (gnt_valid),
      .wdata ({gnt_idx, gnt_payload}),
      .pop   (fifo_pop),
      .rdata (col_data),
      .valid (col_valid),
      .full  (fifo_full)
   );
endmodule

// File: tb/tb_column_readout_rr.sv
// tb/tb_column_readout_rr.sv - directed vector bench for column_readout_rr
module tb_column_readout_rr;
   logic        clk_40MHz = 1'b0;
   logic        rst = 1'b1;
   logic        shutter = 1'b1;
   logic        mode = 1'b0;
   logic [15:0] hit = '0;
   logic [8:0]  TimeStamp = '0;
   logic        shake_hands_col = 1'b1;
   logic [12:0] col_data;
   logic        col_valid;
   logic        hit_or_column;
   logic [7:0]  lost_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] hit;
      logic        exp_valid;
      logic [12:0] exp_data;
      logic        exp_hor;
   } vec_t;
   vec_t tbl [7];

   logic [12:0] words [$];
   logic [8:0]  t_exp;
   logic [8:0]  bp_ts [16];
   logic        seen;

   column_readout_rr dut (
      .clk_40MHz       (clk_40MHz),
      .rst             (rst),
      .shutter         (shutter),
      .mode            (mode),
      .hit             (hit),
      .TimeStamp       (TimeStamp),
      .shake_hands_col (shake_hands_col),
      .col_data        (col_data),
      .col_valid       (col_valid),
      .hit_or_column   (hit_or_column),
      .lost_cnt        (lost_cnt)
   );

   always #5 clk_40MHz = ~clk_40MHz;

   task automatic step();
      @(posedge clk_40MHz);
      #1;
      TimeStamp = TimeStamp + 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      hit = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic collect(input int budget);
      words.delete();
      for (int c = 0; c < budget; c++) begin
         if (col_valid) words.push_back(col_data);
         step();
      end
   endtask

   task automatic pulse(input logic [15:0] mask);
      hit = mask;
      step();
      step();
      hit = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{16'h0000, 1'b0, 13'd0,           1'b0};
      tbl[1] = '{16'h0008, 1'b0, 13'd0,           1'b0};
      tbl[2] = '{16'h0008, 1'b0, 13'd0,           1'b0};
      tbl[3] = '{16'h0000, 1'b0, 13'd0,           1'b1};
      tbl[4] = '{16'h0000, 1'b1, {4'd3, 9'd103},  1'b0};
      tbl[5] = '{16'h0000, 1'b0, 13'd0,           1'b0};
      tbl[6] = '{16'h0000, 1'b0, 13'd0,           1'b0};

      // reset state
      do_reset();
      check("rst_valid", col_valid, 0);
      check("rst_data", col_data, 0);
      check("rst_hor", hit_or_column, 0);
      check("rst_lost", lost_cnt, 0);

      // single hit on pixel 3, cycle-exact
      step();
      TimeStamp = 9'd100;
      for (int j = 0; j < 7; j++) begin
         hit = tbl[j].hit;
         step();
         check($sformatf("sh%0d_valid", j), col_valid, tbl[j].exp_valid);
         check($sformatf("sh%0d_data", j), col_data, tbl[j].exp_data);
         check($sformatf("sh%0d_hor", j), hit_or_column, tbl[j].exp_hor);
      end

      // round robin from rr_ptr=0
      do_reset();
      step();
      t_exp = TimeStamp + 9'd2;
      pulse(16'h8021);
      step();
      check("rr_hor", hit_or_column, 1);
      step();
      check("rr_w0", col_data, {4'd0, t_exp});
      step();
      check("rr_w1", col_data, {4'd5, t_exp});
      step();
      check("rr_w2", col_data, {4'd15, t_exp});
      step();
      check("rr_empty", col_valid, 0);
      step();
      t_exp = TimeStamp + 9'd2;
      pulse(16'h0003);
      step();
      step();
      check("rr_wrap0", col_data, {4'd0, t_exp});
      step();
      check("rr_wrap1", col_data, {4'd1, t_exp});
      step();
      check("rr_wrap_empty", col_valid, 0);

      // backpressure: staggered hits on all pixels
      do_reset();
      shake_hands_col = 1'b0;
      step();
      for (int i = 0; i < 16; i++) begin
         bp_ts[i] = TimeStamp + 9'd2;
         pulse(16'(1 << i));
         step();
      end
      repeat (4) step();
      check("bp_valid", col_valid, 1);
      check("bp_hor", hit_or_column, 1);
      check("bp_lost", lost_cnt, 0);
      check("bp_head", col_data, {4'd0, bp_ts[0]});
      shake_hands_col = 1'b1;
      collect(64);
      check("bp_count", words.size(), 16);
      for (int i = 0; i < 16 && i < words.size(); i++)
         check($sformatf("bp_word%0d", i), words[i], {4'(i), bp_ts[i]});

      // pile-up on pixel 7 while FIFO is full
      do_reset();
      shake_hands_col = 1'b0;
      step();
      pulse(16'hFF00);
      repeat (12) step();
      check("pu_full_hor", hit_or_column, 0);
      t_exp = TimeStamp + 9'd2;
      pulse(16'h0080);
      step();
      step();
      pulse(16'h0080);
      repeat (4) step();
      check("pu_lost", lost_cnt, 1);
      check("pu_hor", hit_or_column, 1);
      shake_hands_col = 1'b1;
      collect(64);
      check("pu_count", words.size(), 9);
      if (words.size() == 9) begin
         check("pu_first", words[0][12:9], 8);
         check("pu_last", words[8], {4'd7, t_exp});
      end

      // counting mode
      do_reset();
      shutter = 1'b0;
      step();
      mode = 1'b1;
      step();
      step();
      shutter = 1'b1;
      step();
      step();
      for (int p = 0; p < 300; p++) begin
         pulse((p < 5) ? 16'h0204 : 16'h0200);
         step();
         step();
      end
      repeat (3) step();
      check("ct_no_flag", hit_or_column, 0);
      shutter = 1'b0;
      step();
      check("ct_hor_m", hit_or_column, 0);
      step();
      check("ct_hor_m1", hit_or_column, 1);
      check("ct_valid_m1", col_valid, 0);
      step();
      check("ct_w0", col_data, {4'd2, 9'd5});
      step();
      check("ct_w1", col_data, {4'd9, 9'd255});
      step();
      check("ct_empty", col_valid, 0);
      shutter = 1'b1;
      repeat (3) step();
      shutter = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         seen = seen | col_valid | hit_or_column;
      end
      check("ct_cleared", seen, 0);

      // reset mid-readout
      mode = 1'b0;
      shutter = 1'b1;
      do_reset();
      shake_hands_col = 1'b0;
      step();
      step();
      pulse(16'h003F);
      repeat (5) step();
      check("mr_valid_pre", col_valid, 1);
      check("mr_hor_pre", hit_or_column, 1);
      #3;
      rst = 1'b1;
      #1;
      check("mr_valid", col_valid, 0);
      check("mr_data", col_data, 0);
      check("mr_hor", hit_or_column, 0);
      check("mr_lost", lost_cnt, 0);
      step();
      step();
      rst = 1'b0;
      shake_hands_col = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         seen = seen | col_valid | hit_or_column;
      end
      check("mr_no_stale", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
